// File: rtl/apb_periph_bridge.sv
// Registered APB4 1-to-NSLV bridge: one upstream slave port fanned out over a shared
// downstream bus with a mask/base address decoder, decode-miss errors and an access watchdog.
module apb_periph_bridge #(
  parameter int unsigned            ADDR_W   = 32,
  parameter int unsigned            DATA_W   = 32,
  parameter int unsigned            NSLV     = 4,
  parameter logic [NSLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NSLV*ADDR_W-1:0] SLV_MASK = '0,
  parameter int unsigned            TIMEOUT  = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_psel,
  input  logic                       s_penable,
  input  logic                       s_pwrite,
  input  logic [ADDR_W-1:0]          s_paddr,
  input  logic [DATA_W-1:0]          s_pwdata,
  input  logic [DATA_W/8-1:0]        s_pstrb,
  input  logic [2:0]                 s_pprot,
  output logic                       s_pready,
  output logic [DATA_W-1:0]          s_prdata,
  output logic                       s_pslverr,
  output logic [NSLV-1:0]            m_psel,
  output logic                       m_penable,
  output logic                       m_pwrite,
  output logic [ADDR_W-1:0]          m_paddr,
  output logic [DATA_W-1:0]          m_pwdata,
  output logic [DATA_W/8-1:0]        m_pstrb,
  output logic [2:0]                 m_pprot,
  input  logic [NSLV-1:0]            m_pready,
  input  logic [NSLV*DATA_W-1:0]     m_prdata,
  input  logic [NSLV-1:0]            m_pslverr,
  output logic                       err_timeout,
  output logic                       err_decode,
  output logic [$clog2(NSLV+1)-1:0]  err_idx
);

  localparam int unsigned IDX_W = $clog2(NSLV + 1);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_start;
  logic                w_hit;
  logic [IDX_W-1:0]    w_idx;
  logic                w_sel_ready;
  logic                w_sel_err;
  logic [DATA_W-1:0]   w_sel_rdata;
  logic                w_timeout;

  logic [IDX_W-1:0]    r_idx;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_strb;
  logic [2:0]          r_prot;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_slverr;
  logic                r_drop;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err_to;
  logic                r_err_dec;
  logic [IDX_W-1:0]    r_err_idx;

  assign w_start   = s_psel & ~s_penable;
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  // Lowest matching index wins when ranges overlap.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (!w_hit && ((s_paddr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
        w_hit = 1'b1;
        w_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_err   = 1'b0;
    w_sel_rdata = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_sel_ready = m_pready[i];
        w_sel_err   = m_pslverr[i];
        w_sel_rdata = m_prdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_start) w_next = w_hit ? ST_SETUP : ST_RESP;
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: if (w_sel_ready || w_timeout) w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= '0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_prot    <= '0;
      r_rdata   <= '0;
      r_slverr  <= 1'b0;
      r_drop    <= 1'b0;
      r_cnt     <= '0;
      r_err_to  <= 1'b0;
      r_err_dec <= 1'b0;
      r_err_idx <= '0;
    end else begin
      r_err_to  <= 1'b0;
      r_err_dec <= 1'b0;
      unique case (r_state)
        ST_IDLE: if (w_start) begin
          r_idx    <= w_hit ? w_idx : IDX_W'(NSLV);
          r_write  <= s_pwrite;
          r_addr   <= s_paddr;
          r_wdata  <= s_pwdata;
          r_strb   <= s_pstrb;
          r_prot   <= s_pprot;
          r_drop   <= 1'b0;
          r_cnt    <= '0;
          r_rdata  <= '0;
          r_slverr <= ~w_hit;
          if (!w_hit) begin
            r_err_dec <= 1'b1;
            r_err_idx <= IDX_W'(NSLV);
          end
        end
        ST_SETUP: if (!s_psel) r_drop <= 1'b1;
        ST_ACCESS: begin
          if (!s_psel) r_drop <= 1'b1;
          // A ready in the final watchdog cycle takes priority over the abort.
          if (w_sel_ready) begin
            r_rdata  <= w_sel_rdata;
            r_slverr <= w_sel_err;
            if (w_sel_err) r_err_idx <= r_idx;
          end else if (w_timeout) begin
            r_rdata   <= '0;
            r_slverr  <= 1'b1;
            r_err_to  <= 1'b1;
            r_err_idx <= r_idx;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: r_cnt <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    s_pready    = (r_state == ST_RESP) & s_psel & ~r_drop;
    s_pslverr   = s_pready & r_slverr;
    s_prdata    = (s_pready & ~r_write) ? r_rdata : '0;
    m_penable   = (r_state == ST_ACCESS);
    m_pwrite    = r_write;
    m_paddr     = r_addr;
    m_pwdata    = r_wdata;
    m_pstrb     = r_strb;
    m_pprot     = r_prot;
    err_timeout = r_err_to;
    err_decode  = r_err_dec;
    err_idx     = r_err_idx;
    m_psel      = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      m_psel[i] = ((r_state == ST_SETUP) || (r_state == ST_ACCESS)) && (r_idx == IDX_W'(i));
    end
  end

endmodule

// File: tb/tb_apb_periph_bridge.sv
// Self-checking bench for apb_periph_bridge: directed corner cases plus randomized
// transfers compared against a transaction-level model of decode, latency and errors.
module tb_apb_periph_bridge;

  localparam int NSLV = 4;
  localparam int TMO  = 8;
  localparam logic [31:0] BASE [NSLV] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h2000_0000};
  localparam logic [31:0] MASK [NSLV] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hE000_0000};

  logic              clk = 1'b0;
  logic              rst;
  logic              s_psel, s_penable, s_pwrite;
  logic [31:0]       s_paddr, s_pwdata;
  logic [3:0]        s_pstrb;
  logic [2:0]        s_pprot;
  logic              s_pready, s_pslverr;
  logic [31:0]       s_prdata;
  logic [NSLV-1:0]   m_psel;
  logic              m_penable, m_pwrite;
  logic [31:0]       m_paddr, m_pwdata;
  logic [3:0]        m_pstrb;
  logic [2:0]        m_pprot;
  logic [NSLV-1:0]   m_pready, m_pslverr;
  logic [NSLV*32-1:0] m_prdata;
  logic              err_timeout, err_decode;
  logic [2:0]        err_idx;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sl_data [NSLV];
  int          model_err_idx = 0;

  always #5 clk = ~clk;

  apb_periph_bridge #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .NSLV     (NSLV),
    .SLV_BASE ({BASE[3], BASE[2], BASE[1], BASE[0]}),
    .SLV_MASK ({MASK[3], MASK[2], MASK[1], MASK[0]}),
    .TIMEOUT  (TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite), .s_paddr(s_paddr),
    .s_pwdata(s_pwdata), .s_pstrb(s_pstrb), .s_pprot(s_pprot),
    .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite), .m_paddr(m_paddr),
    .m_pwdata(m_pwdata), .m_pstrb(m_pstrb), .m_pprot(m_pprot),
    .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr),
    .err_timeout(err_timeout), .err_decode(err_decode), .err_idx(err_idx)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NSLV; i++)
      if ((a & MASK[i]) == BASE[i]) return i;
    return NSLV;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_up"}, {s_pready, s_pslverr, s_prdata}, 64'd0);
    check({tag, "_dn"}, {m_psel, m_penable, m_pwrite, m_pstrb, m_pprot}, 64'd0);
    check({tag, "_bus"}, {m_paddr, m_pwdata}, 64'd0);
    check({tag, "_err"}, {err_timeout, err_decode, err_idx}, 64'd0);
  endtask

  // One upstream transfer; waits = ready-low ACCESS cycles before ready.
  task automatic run_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input logic [31:0] rd, input bit serr, input bit drop);
    int e, acc, lat, ndec, nto, bound, exp_acc, exp_lat;
    bit psel_ok, bus_ok, rd_ok, tmo;
    logic [31:0] got_rd, exp_rd;
    logic got_err, exp_err;
    logic [2:0] got_idx;
    logic [3:0] strb;
    logic [2:0] prot;
    e = decode(addr);
    strb = 4'($urandom_range(0, 15));
    prot = 3'($urandom_range(0, 7));
    for (int k = 0; k < NSLV; k++) begin
      sl_data[k] = $urandom;
      if (k == e) sl_data[k] = rd;
      m_prdata[k*32 +: 32] = sl_data[k];
    end
    m_pslverr = 4'($urandom_range(0, 15));
    if (e < NSLV) m_pslverr[e] = serr;
    m_pready = '0;
    acc = 0; lat = -1; ndec = 0; nto = 0;
    psel_ok = 1; bus_ok = 1; rd_ok = 1;
    got_rd = '0; got_err = 1'b0; got_idx = '0;
    bound = drop ? 20 : 40;
    @(posedge clk); #1;
    s_psel = 1; s_penable = 0; s_pwrite = wr; s_paddr = addr;
    s_pwdata = wdata; s_pstrb = strb; s_pprot = prot;
    for (int c = 1; c <= bound; c++) begin
      @(posedge clk); #1;
      if (c == 1) s_penable = 1;
      if (drop && c == 2) begin s_psel = 0; s_penable = 0; end
      if (m_psel != 0 && (e == NSLV || m_psel != 4'(1 << e))) psel_ok = 0;
      if (m_psel != 0 && (m_paddr != addr || m_pwrite != wr || m_pwdata != wdata ||
                          m_pstrb != strb || m_pprot != prot)) bus_ok = 0;
      if (!s_pready && s_prdata != 0) rd_ok = 0;
      ndec += int'(err_decode);
      nto  += int'(err_timeout);
      if (s_pready) begin
        lat = c; got_rd = s_prdata; got_err = s_pslverr; got_idx = err_idx;
        break;
      end
      m_pready = (m_penable && acc == waits) ? '1 : '0;
      if (m_penable) acc++;
    end
    s_psel = 0; s_penable = 0; m_pready = '0;

    tmo     = (e < NSLV) && (waits >= TMO);
    exp_acc = (e == NSLV) ? 0 : (tmo ? TMO : waits + 1);
    exp_lat = (e == NSLV) ? 1 : 2 + exp_acc;
    exp_err = (e == NSLV) || tmo || serr;
    exp_rd  = ((e == NSLV) || tmo || wr) ? 32'd0 : sl_data[e];
    if (e == NSLV) model_err_idx = NSLV;
    else if (tmo || serr) model_err_idx = e;

    check("psel_onehot", 64'(psel_ok), 64'd1);
    check("bus_hold", 64'(bus_ok), 64'd1);
    check("access_cycles", 64'(acc), 64'(exp_acc));
    if (drop) begin
      check("drop_no_ready", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
      check("drop_psel_idle", 64'(m_psel), 64'd0);
    end else begin
      check("latency", 64'(lat), 64'(exp_lat));
      check("prdata", 64'(got_rd), 64'(exp_rd));
      check("pslverr", 64'(got_err), 64'(exp_err));
      check("prdata_quiet", 64'(rd_ok), 64'd1);
      check("err_decode_pulses", 64'(ndec), 64'(e == NSLV));
      check("err_timeout_pulses", 64'(nto), 64'(tmo));
      check("err_idx", 64'(got_idx), 64'(model_err_idx));
    end
  endtask

  initial begin
    rst = 1; s_psel = 0; s_penable = 0; s_pwrite = 0; s_paddr = '0;
    s_pwdata = '0; s_pstrb = '0; s_pprot = '0;
    m_pready = '0; m_pslverr = '0; m_prdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 0;

    run_xfer(1'b0, 32'h1000_0010, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    run_xfer(1'b1, 32'h7000_0000, 32'h1234_5678, 0, 32'h0, 1'b0, 1'b0);
    run_xfer(1'b0, 32'h2000_0004, 32'h0, 1000, 32'h5555_AAAA, 1'b0, 1'b0);
    run_xfer(1'b0, 32'h2000_0008, 32'h0, TMO - 1, 32'h0BAD_F00D, 1'b0, 1'b0);
    run_xfer(1'b0, 32'h3000_0040, 32'h0, 5, 32'hCAFE_0003, 1'b1, 1'b0);
    run_xfer(1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 2, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_xfer(1'b0, 32'h1000_0000, 32'h0, 1, 32'h1111_2222, 1'b0, 1'b1);

    // Reset during ACCESS, then a fresh read that needs a cleared watchdog.
    @(posedge clk); #1;
    s_psel = 1; s_penable = 0; s_pwrite = 0; s_paddr = 32'h2000_0000;
    m_pready = '0;
    @(posedge clk); #1; s_penable = 1;
    repeat (4) @(posedge clk);
    #1; rst = 1;
    @(posedge clk); #1;
    check_idle_outputs("midreset");
    rst = 0; s_psel = 0; s_penable = 0;
    model_err_idx = 0;
    run_xfer(1'b0, 32'h0000_0020, 32'h0, 6, 32'h600D_0000, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      logic [31:0] a;
      int r, w;
      a = $urandom;
      a[31:28] = 4'($urandom_range(0, 9));
      r = $urandom_range(0, 9);
      w = (r < 5) ? r : (r == 5) ? TMO - 1 : (r == 6) ? TMO : (r == 7) ? 12 : 0;
      run_xfer(1'($urandom_range(0, 1)), a, $urandom, w, $urandom,
               ($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
